ir_frame_tx_param: RTL and testbench
====================================

// Module: ir_frame_tx_param
// PURPOSE
// - Parametrised IR remote-control frame transmitter, replacing the fixed 35+32-bit air-conditioner sender.
// - Frame: header -> segment 1 -> connect gap -> segment 2 -> stop mark. The output is carrier-modulated, ready to drive the IR LED.
// - Frames are loaded by a valid/ready handshake from the key/command logic. The block reports busy/done and supports abort.
// PARAMETERS
// CLK_HZ         100_000_000  system clock frequency (Hz); must be a multiple of 1_000_000
// CARRIER_HZ     38_000       carrier frequency; CARR_DIV = CLK_HZ/CARRIER_HZ
// SEG1_BITS      35           segment-1 length in bits; >= 1
// SEG2_BITS      32           segment-2 length in bits; >= 1
// MSB_FIRST      1            1: send bit [N-1] first; 0: send bit [0] first
// HDR_MARK_US    9000         header carrier-on time (us)
// HDR_SPACE_US   4500         header carrier-off time (us)
// BIT_MARK_US    750          mark time of every data bit, connect gap and stop mark (us)
// ZERO_SPACE_US  450          space after the mark of a '0' bit (us)
// ONE_SPACE_US   1500         space after the mark of a '1' bit (us)
// CONN_SPACE_US  20000        space after the connect mark (us)
// PORTS
// clk          in   1          system clock
// rst          in   1          reset, synchronous, active-low
// frame_valid  in   1          frame available on seg1_data/seg2_data
// frame_ready  out  1          block can accept a frame (IDLE)
// seg1_data    in   SEG1_BITS  segment-1 payload, sampled on acceptance
// seg2_data    in   SEG2_BITS  segment-2 payload, sampled on acceptance
// abort        in   1          cancel the current frame
// busy         out  1          frame in progress (any state except IDLE)
// done         out  1          1-cycle pulse on normal frame completion
// env_out      out  1          unmodulated envelope: 1 = mark, 0 = space
// ir_out       out  1          env_out AND carrier; drives the IR LED
// BEHAVIOUR
// - Reset (rst=0 at a clock edge): state IDLE, all outputs 0, carrier counter 0, shift registers 0.
//   frame_ready rises in the first cycle after rst is released.
// - Carrier: free-running counter 0..CARR_DIV-1. carrier=1 when cnt >= CARR_DIV/2.
//   ir_out = env_out & carrier, registered, so one cycle later than env_out.
// - Handshake: frame_ready = (state==IDLE). Accept when frame_valid & frame_ready: latch both segments and enter HDR_MARK on the next cycle.
//   frame_valid is ignored while busy; no queueing.
// - Every phase lasts exactly US*(CLK_HZ/1e6) cycles, counted by one down-counter reloaded on each phase entry.
// - States and transitions:
//   IDLE -> HDR_MARK -> HDR_SPACE -> BIT_MARK -> BIT_SPACE
//   BIT_SPACE -> BIT_MARK (more bits) | CONN_MARK (end of seg1) | STOP_MARK (end of seg2)
//   CONN_MARK -> CONN_SPACE -> BIT_MARK (seg2, bit counter reloaded)
//   STOP_MARK -> IDLE with done=1 in the cycle IDLE is entered
// - BIT_SPACE length is ONE_SPACE_US when the current bit is 1, otherwise ZERO_SPACE_US. Bits are taken from the shift register in MSB_FIRST order.
// - env_out=1 in HDR_MARK, BIT_MARK, CONN_MARK and STOP_MARK; 0 in every other state.
// - Abort: in any non-IDLE state, the next state is IDLE; env_out and ir_out go 0 within 1 cycle; done is not pulsed.
//   Abort in IDLE has no effect. Abort together with frame_valid in IDLE: abort wins and the frame is not accepted.
// - Reset mid-frame behaves as abort, and all outputs return to their reset values.
// - Counter widths come from $clog2 of the largest phase and of max(SEG1_BITS,SEG2_BITS); counters never wrap inside a phase.
// TESTING (CLK_HZ=1_000_000, i.e. 1 cycle = 1 us; CARR_DIV=26)
// - Reset: hold rst=0 for 5 cycles -> ir_out=env_out=busy=done=0, frame_ready=0; one cycle after release frame_ready=1.
// - Frame: SEG1_BITS=3, SEG2_BITS=2, seg1=3'b101, seg2=2'b01, MSB_FIRST=1
//   -> env_out marks/spaces 9000/4500, 750/1500, 750/450, 750/1500, 750/20000, 750/450, 750/1500, 750
//   -> done is pulsed 44150 cycles after HDR_MARK entry.
// - Repeat the frame with MSB_FIRST=0 -> seg1 is sent as 1,0,1 and seg2 as 1,0 (spaces 1500, 450).
// - Carrier: during HDR_MARK, ir_out is high for 13 of every 26 cycles; during spaces and IDLE ir_out stays 0.
// - Abort at cycle 5000 of CONN_SPACE -> IDLE next cycle, no done pulse, frame_ready=1. A new frame is then accepted normally.
// - frame_valid held high while busy and at done -> exactly one frame per IDLE visit; back-to-back acceptance occurs in the cycle after done.

Source files
------------

// File: rtl/ir_frame_tx_param.sv
// IR remote frame transmitter: header, segment 1, connect gap, segment 2, stop mark.
// Takes one frame per IDLE visit (no queueing); ir_out is the carrier-gated envelope, one cycle behind env_out.
module ir_frame_tx_param #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int CARRIER_HZ    = 38_000,
  parameter int SEG1_BITS     = 35,
  parameter int SEG2_BITS     = 32,
  parameter int MSB_FIRST     = 1,
  parameter int HDR_MARK_US   = 9000,
  parameter int HDR_SPACE_US  = 4500,
  parameter int BIT_MARK_US   = 750,
  parameter int ZERO_SPACE_US = 450,
  parameter int ONE_SPACE_US  = 1500,
  parameter int CONN_SPACE_US = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [SEG1_BITS-1:0] seg1_data,
  input  logic [SEG2_BITS-1:0] seg2_data,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 env_out,
  output logic                 ir_out
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CPU        = CLK_HZ / 1_000_000;
  localparam int CARR_DIV   = CLK_HZ / CARRIER_HZ;
  localparam int HDR_M_CYC  = HDR_MARK_US * CPU;
  localparam int HDR_S_CYC  = HDR_SPACE_US * CPU;
  localparam int BIT_M_CYC  = BIT_MARK_US * CPU;
  localparam int ZERO_CYC   = ZERO_SPACE_US * CPU;
  localparam int ONE_CYC    = ONE_SPACE_US * CPU;
  localparam int CONN_CYC   = CONN_SPACE_US * CPU;
  localparam int MAX_CYC    = imax(imax(imax(HDR_M_CYC, HDR_S_CYC), imax(BIT_M_CYC, ZERO_CYC)),
                                   imax(ONE_CYC, CONN_CYC));
  localparam int CW         = $clog2(MAX_CYC + 1);
  localparam int BW         = $clog2(imax(SEG1_BITS, SEG2_BITS) + 1);
  localparam int KW         = $clog2(CARR_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_MARK, S_HDR_SPACE, S_BIT_MARK, S_BIT_SPACE, S_CONN_MARK, S_CONN_SPACE, S_STOP_MARK
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 seg2_sel_q, seg2_sel_d;
  logic [SEG1_BITS-1:0] sr1_q, sr1_d;
  logic [SEG2_BITS-1:0] sr2_q, sr2_d;
  logic [KW-1:0]        car_q, car_d;
  logic                 frame_ready_q, frame_ready_d;
  logic                 done_q, done_d;
  logic                 ir_q, ir_d;
  logic                 cur_bit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      seg2_sel_q    <= 1'b0;
      sr1_q         <= '0;
      sr2_q         <= '0;
      car_q         <= '0;
      frame_ready_q <= 1'b0;
      done_q        <= 1'b0;
      ir_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      seg2_sel_q    <= seg2_sel_d;
      sr1_q         <= sr1_d;
      sr2_q         <= sr2_d;
      car_q         <= car_d;
      frame_ready_q <= frame_ready_d;
      done_q        <= done_d;
      ir_q          <= ir_d;
    end
  end

  // The bit on air sits at the end of the shift register that is sent first.
  assign cur_bit = (MSB_FIRST != 0)
                 ? (seg2_sel_q ? sr2_q[SEG2_BITS-1] : sr1_q[SEG1_BITS-1])
                 : (seg2_sel_q ? sr2_q[0] : sr1_q[0]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    seg2_sel_d = seg2_sel_q;
    sr1_d      = sr1_q;
    sr2_d      = sr2_q;
    done_d     = 1'b0;
    if (state_q == S_IDLE) begin
      if (frame_valid && frame_ready_q && !abort) begin
        state_d    = S_HDR_MARK;
        cnt_d      = CW'(HDR_M_CYC - 1);
        sr1_d      = seg1_data;
        sr2_d      = seg2_data;
        bit_cnt_d  = BW'(SEG1_BITS - 1);
        seg2_sel_d = 1'b0;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      case (state_q)
        S_HDR_MARK:  begin state_d = S_HDR_SPACE; cnt_d = CW'(HDR_S_CYC - 1); end
        S_HDR_SPACE: begin state_d = S_BIT_MARK;  cnt_d = CW'(BIT_M_CYC - 1); end
        S_BIT_MARK: begin
          state_d = S_BIT_SPACE;
          cnt_d   = cur_bit ? CW'(ONE_CYC - 1) : CW'(ZERO_CYC - 1);
        end
        S_BIT_SPACE: begin
          cnt_d = CW'(BIT_M_CYC - 1);
          if (bit_cnt_q != '0) begin
            state_d   = S_BIT_MARK;
            bit_cnt_d = bit_cnt_q - BW'(1);
            if (seg2_sel_q) sr2_d = (MSB_FIRST != 0) ? (sr2_q << 1) : (sr2_q >> 1);
            else            sr1_d = (MSB_FIRST != 0) ? (sr1_q << 1) : (sr1_q >> 1);
          end else begin
            state_d = seg2_sel_q ? S_STOP_MARK : S_CONN_MARK;
          end
        end
        S_CONN_MARK:  begin state_d = S_CONN_SPACE; cnt_d = CW'(CONN_CYC - 1); end
        S_CONN_SPACE: begin
          state_d    = S_BIT_MARK;
          cnt_d      = CW'(BIT_M_CYC - 1);
          bit_cnt_d  = BW'(SEG2_BITS - 1);
          seg2_sel_d = 1'b1;
        end
        S_STOP_MARK: begin state_d = S_IDLE; done_d = 1'b1; end
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    env_out       = (state_q == S_HDR_MARK) || (state_q == S_BIT_MARK) ||
                    (state_q == S_CONN_MARK) || (state_q == S_STOP_MARK);
    busy          = (state_q != S_IDLE);
    frame_ready   = frame_ready_q;
    done          = done_q;
    ir_out        = ir_q;
    frame_ready_d = (state_d == S_IDLE);
    car_d         = (car_q == KW'(CARR_DIV - 1)) ? '0 : car_q + KW'(1);
    ir_d          = env_out && (car_q >= KW'(CARR_DIV / 2));
  end

endmodule

// File: tb/tb_ir_frame_tx_param.sv
// Bench for ir_frame_tx_param: two instances (MSB-first and LSB-first) checked against
// a mark/space run-list model built from the frame timing rules.
`timescale 1ns/1ps
module tb_ir_frame_tx_param;
  localparam int N1 = 3;
  localparam int N2 = 2;

  typedef struct { bit lvl; int len; } run_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fv_m = 1'b0, fv_l = 1'b0, abort = 1'b0;
  logic [N1-1:0] seg1 = '0;
  logic [N2-1:0] seg2 = '0;
  logic rdy_m, busy_m, done_m, env_m, ir_m;
  logic rdy_l, busy_l, done_l, env_l, ir_l;
  logic [N1-1:0] f2_s1;
  logic [N2-1:0] f2_s2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ir_frame_tx_param #(.CLK_HZ(1_000_000), .CARRIER_HZ(38_000), .SEG1_BITS(N1), .SEG2_BITS(N2),
                      .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .frame_valid(fv_m), .frame_ready(rdy_m), .seg1_data(seg1),
    .seg2_data(seg2), .abort(abort), .busy(busy_m), .done(done_m), .env_out(env_m), .ir_out(ir_m));

  ir_frame_tx_param #(.CLK_HZ(1_000_000), .CARRIER_HZ(38_000), .SEG1_BITS(N1), .SEG2_BITS(N2),
                      .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .frame_valid(fv_l), .frame_ready(rdy_l), .seg1_data(seg1),
    .seg2_data(seg2), .abort(abort), .busy(busy_l), .done(done_l), .env_out(env_l), .ir_out(ir_l));

  // Expected envelope as a list of (level, duration in cycles) runs.
  task automatic build_runs(input logic [N1-1:0] s1, input logic [N2-1:0] s2, input bit msb,
                            output run_t q[$]);
    run_t r;
    bit b;
    q = {};
    r.lvl = 1; r.len = 9000; q.push_back(r);
    r.lvl = 0; r.len = 4500; q.push_back(r);
    for (int i = 0; i < N1; i++) begin
      b = msb ? s1[N1-1-i] : s1[i];
      r.lvl = 1; r.len = 750; q.push_back(r);
      r.lvl = 0; r.len = b ? 1500 : 450; q.push_back(r);
    end
    r.lvl = 1; r.len = 750; q.push_back(r);
    r.lvl = 0; r.len = 20000; q.push_back(r);
    for (int i = 0; i < N2; i++) begin
      b = msb ? s2[N2-1-i] : s2[i];
      r.lvl = 1; r.len = 750; q.push_back(r);
      r.lvl = 0; r.len = b ? 1500 : 450; q.push_back(r);
    end
    r.lvl = 1; r.len = 750; q.push_back(r);
  endtask

  function automatic int total(input run_t q[$]);
    int s = 0;
    foreach (q[i]) s += q[i].len;
    return s;
  endfunction

  function automatic bit exp_level(input run_t q[$], input int c);
    int t = 0;
    foreach (q[i]) begin
      if (c < t + q[i].len) return q[i].lvl;
      t += q[i].len;
    end
    return 1'b0;
  endfunction

  // Called at the negedge of the first HDR_MARK cycle; compares each completed envelope run.
  task automatic watch(input bit sel, input run_t xq[$], input int stop_at, input bit expect_done,
                       output int end_cyc);
    int k, len, irh, bad, c, wl, wn;
    bit cur, e, got_done;
    k = 0; len = 0; irh = 0; bad = 0; c = 0; cur = 1'b0; got_done = 1'b0;
    while (c < stop_at) begin
      e = sel ? env_l : env_m;
      if (c == 0) begin
        cur = e; len = 1;
      end else if (e != cur) begin
        wl = -1; wn = -1;
        if (k < xq.size()) begin wl = int'(xq[k].lvl); wn = xq[k].len; end
        checks++;
        if (wl != int'(cur) || wn != len) begin
          failures++;
          $display("FAIL run[%0d] inst=%0d: got lvl=%0d len=%0d, want lvl=%0d len=%0d",
                   k, sel, cur, len, wl, wn);
        end
        k++; cur = e; len = 1;
      end else begin
        len++;
      end
      if ((sel ? done_l : done_m) === 1'b1) begin got_done = 1'b1; break; end
      if ((sel ? busy_l : busy_m) !== 1'b1 || (sel ? rdy_l : rdy_m) !== 1'b0) bad++;
      if (!e && len > 1 && (sel ? ir_l : ir_m) !== 1'b0) bad++;
      if (c >= 1 && c <= 260 && (sel ? ir_l : ir_m) === 1'b1) irh++;
      @(negedge clk);
      c++;
    end
    end_cyc = c;
    checks++;
    if (got_done !== expect_done) begin
      failures++;
      $display("FAIL done_seen inst=%0d: got %0d want %0d", sel, got_done, expect_done);
    end
    if (expect_done) begin
      checks++;
      if (c != total(xq)) begin
        failures++;
        $display("FAIL done_cycle inst=%0d: got %0d want %0d", sel, c, total(xq));
      end
      checks++;
      if (k != xq.size()) begin
        failures++;
        $display("FAIL run_count inst=%0d: got %0d want %0d", sel, k, xq.size());
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL status_in_frame inst=%0d: got %0d bad cycles want 0", sel, bad);
    end
    checks++;
    if (irh != 130) begin
      failures++;
      $display("FAIL carrier_duty inst=%0d: got %0d high of 260 want 130", sel, irh);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; fv_m = 1'b0; fv_l = 1'b0; abort = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ir_m, env_m, busy_m, done_m, rdy_m, ir_l, env_l, busy_l, done_l, rdy_l} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0", {ir_m, env_m, busy_m, done_m, rdy_m,
                                                    ir_l, env_l, busy_l, done_l, rdy_l});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_m !== 1'b1 || rdy_l !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b%b want 11", rdy_m, rdy_l);
    end
  endtask

  task automatic test_frame;
    run_t qm[$], ql[$];
    int e1, e2;
    seg1 = 3'b101; seg2 = 2'b01;
    build_runs(3'b101, 2'b01, 1'b1, qm);
    build_runs(3'b101, 2'b01, 1'b0, ql);
    fv_m = 1'b1; fv_l = 1'b1;
    @(negedge clk);
    fv_l = 1'b0;
    // New payload while busy: must not affect the frame in flight, becomes frame 2.
    f2_s1 = N1'($urandom); f2_s2 = N2'($urandom);
    seg1 = f2_s1; seg2 = f2_s2;
    fork
      watch(1'b0, qm, 50000, 1'b1, e1);
      watch(1'b1, ql, 50000, 1'b1, e2);
    join
    checks++;
    if (e1 != 44150 || e2 != 44150) begin
      failures++;
      $display("FAIL frame_length: got %0d/%0d want 44150", e1, e2);
    end
    checks++;
    if (rdy_m !== 1'b1) begin
      failures++;
      $display("FAIL ready_at_done: got %b want 1", rdy_m);
    end
    @(negedge clk);
    fv_m = 1'b0;
    checks++;
    if (busy_m !== 1'b1 || env_m !== 1'b1 || busy_l !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back: got busy_m=%b env_m=%b busy_l=%b want 1 1 0", busy_m, env_m, busy_l);
    end
  endtask

  task automatic test_abort;
    run_t q[$];
    int t_conn, e, dn;
    build_runs(f2_s1, f2_s2, 1'b1, q);
    t_conn = 0;
    for (int i = 0; i < 2 + 2 * N1 + 1; i++) t_conn += q[i].len;
    watch(1'b0, q, t_conn + 5000, 1'b0, e);
    checks++;
    if (env_m !== 1'b0 || busy_m !== 1'b1) begin
      failures++;
      $display("FAIL in_conn_space: got env=%b busy=%b want 0 1", env_m, busy_m);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy_m !== 1'b0 || rdy_m !== 1'b1 || env_m !== 1'b0 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL abort_to_idle: got busy=%b rdy=%b env=%b done=%b want 0 1 0 0",
               busy_m, rdy_m, env_m, done_m);
    end
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_m !== 1'b0 || ir_m !== 1'b0 || busy_m !== 1'b0) dn++;
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL idle_after_abort: got %0d active cycles want 0", dn);
    end
  endtask

  task automatic test_random_abort;
    run_t q[$];
    logic [N1-1:0] s1;
    logic [N2-1:0] s2;
    int r, err;
    for (int it = 0; it < 4; it++) begin
      s1 = N1'($urandom); s2 = N2'($urandom);
      seg1 = s1; seg2 = s2;
      build_runs(s1, s2, 1'b1, q);
      fv_m = 1'b1;
      @(negedge clk);
      fv_m = 1'b0;
      checks++;
      if (busy_m !== 1'b1 || env_m !== 1'b1) begin
        failures++;
        $display("FAIL accept[%0d]: got busy=%b env=%b want 1 1", it, busy_m, env_m);
      end
      r = int'($urandom_range(2000, 20));
      err = 0;
      for (int c = 0; c < r; c++) begin
        if (env_m !== exp_level(q, c) || done_m !== 1'b0) err++;
        @(negedge clk);
      end
      checks++;
      if (err != 0) begin
        failures++;
        $display("FAIL env_vs_model[%0d]: got %0d bad cycles want 0", it, err);
      end
      if (it == 3) rst = 1'b0;
      else abort = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_m !== 1'b0 || env_m !== 1'b0 || done_m !== 1'b0 || rdy_m !== (it != 3)) begin
        failures++;
        $display("FAIL cancel[%0d]: got busy=%b env=%b done=%b rdy=%b", it, busy_m, env_m, done_m, rdy_m);
      end
      rst = 1'b1; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (ir_m !== 1'b0 || rdy_m !== 1'b1 || busy_m !== 1'b0) begin
        failures++;
        $display("FAIL settle[%0d]: got ir=%b rdy=%b busy=%b want 0 1 0", it, ir_m, rdy_m, busy_m);
      end
    end
  endtask

  task automatic test_abort_vs_valid;
    abort = 1'b1; fv_m = 1'b1;
    @(negedge clk);
    abort = 1'b0; fv_m = 1'b0;
    checks++;
    if (busy_m !== 1'b0 || rdy_m !== 1'b1) begin
      failures++;
      $display("FAIL abort_beats_valid: got busy=%b rdy=%b want 0 1", busy_m, rdy_m);
    end
    fv_m = 1'b1;
    @(negedge clk);
    fv_m = 1'b0;
    checks++;
    if (busy_m !== 1'b1 || env_m !== 1'b1) begin
      failures++;
      $display("FAIL accept_after_abort: got busy=%b env=%b want 1 1", busy_m, env_m);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy_m !== 1'b0) begin
      failures++;
      $display("FAIL final_abort: got busy=%b want 0", busy_m);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_abort;
    test_random_abort;
    test_abort_vs_valid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
